window_mean_sub_stream: RTL and testbench
=========================================

// Module: window_mean_sub_stream
// PURPOSE
//  Streaming zero-mean stage for the star-tracker window path. Accepts one WIN_DIM x WIN_DIM
//  window of unsigned pixels in raster order over a valid/ready stream, buffers it and
//  accumulates its sum. It then computes the window mean (optionally rounded) and replays the
//  window as signed pixel-minus-mean samples. Sits between the window extractor and the correlator.
// PARAMETERS
//  PIX_W    8   input pixel width (unsigned); output sample width is PIX_W+1 (signed)
//  WIN_DIM  16  window edge; must be a power of 2, >= 2; N = WIN_DIM*WIN_DIM pixels per window
//  ROUND    0   0: mean = floor(sum/N); 1: mean = floor((sum + N/2)/N) (round half up)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  flush      in   1         synchronous abort: discard current window, return to LOAD
//  in_valid   in   1         in_pix valid
//  in_ready   out  1         block accepts in_pix this cycle
//  in_pix     in   PIX_W     unsigned pixel, raster order
//  out_valid  out  1         out_data valid
//  out_ready  in   1         downstream accepts out_data this cycle
//  out_data   out  PIX_W+1   signed pixel - mean
//  out_last   out  1         marks sample N-1 of the window
//  mean       out  PIX_W     mean of most recently completed window
// BEHAVIOUR
//  - One clock; reset asynchronous and active-low. Reset: state=LOAD, count=0, sum=0, in_ready=1,
//    out_valid=0, out_last=0, out_data=0, mean=0. Reset mid-window discards all data.
//  - SUM_W = PIX_W + 2*log2(WIN_DIM); SHIFT = 2*log2(WIN_DIM). sum never overflows; rounded
//    (sum + N/2) >> SHIFT <= 2^PIX_W-1, so no saturation needed.
//  - Buffer: N x PIX_W storage, written at index count on accept, read in index order on drain.
//  - FSM LOAD: in_ready=1. Accept when in_valid&&in_ready: buf[count]<=in_pix,
//    sum<=sum+in_pix, count++. On accepting index N-1 -> CALC.
//  - FSM CALC (exactly 1 cycle): in_ready=0; mean<=sum>>SHIFT (ROUND=0) or
//    (sum+N/2)>>SHIFT (ROUND=1); count<=0 -> DRAIN.
//  - FSM DRAIN: in_ready=0. out_valid rises in the cycle after CALC, i.e. first output
//    2 cycles after the last input handshake. out_data = $signed({1'b0,buf[k]}) -
//    $signed({1'b0,mean}), range [-(2^PIX_W-1), 2^PIX_W-1]. Advance k on out_valid&&out_ready;
//    back-to-back 1 sample/cycle when out_ready held high.
//  - Hold rule: while out_valid && !out_ready, out_data/out_last stay stable; out_valid never
//    drops without a handshake (except flush/reset).
//  - out_last=1 only with sample N-1; its handshake -> LOAD with sum=0, count=0, and in_ready=1
//    the next cycle. mean holds its value until the next CALC.
//  - flush: highest priority after reset, any state. Next cycle: LOAD, count=0, sum=0,
//    out_valid=0; mean retained. An input handshake in the flush cycle is dropped.
//  - Throughput: N + 1 + N cycles per window with no stalls. Input and output never overlap.
// TESTING
//  1 Reset: rst_n low mid-LOAD -> in_ready=1, out_valid=0, mean=0 asynchronously; next window clean.
//  2 Constant: 256 pixels of 100 -> mean=100, 256 outputs of 0, out_last on 256th only,
//    first out_valid 2 cycles after last accept.
//  3 Ramp 0..255, ROUND=0 -> mean=127, outputs -127..128; ROUND=1 -> mean=128, outputs -128..127.
//  4 Extremes: all 255 -> mean=255, outputs 0; one 255 and 255 zeros -> mean=0 (ROUND=0),
//    outputs 255 then 0; all 0 -> all 0.
//  5 Backpressure: random out_ready (50%) and in_valid gaps -> same sequence as scenario 3,
//    data stable while stalled, in_ready=0 throughout CALC/DRAIN.
//  6 Flush after 100 accepted pixels, and again mid-DRAIN -> no further out_valid,
//    next full window of 50s yields mean=50, all outputs 0.

Source files
------------

// File: rtl/window_mean_sub_stream.sv
// rtl/window_mean_sub_stream.sv - buffers one pixel window, computes its mean, replays pixel-minus-mean
module window_mean_sub_stream #(
  parameter int PIX_W   = 8,
  parameter int WIN_DIM = 16,
  parameter int ROUND   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W:0]     out_data,
  output logic               out_last,
  output logic [PIX_W-1:0]   mean
);

  localparam int SHIFT = 2 * $clog2(WIN_DIM);
  localparam int N     = WIN_DIM * WIN_DIM;
  localparam int SUM_W = PIX_W + SHIFT;
  localparam int CNT_W = SHIFT;
  localparam logic [SUM_W-1:0] HALF_N   = SUM_W'(N / 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

  state_t             state;
  logic [PIX_W-1:0]   pix_buf [N];
  logic [SUM_W-1:0]   sum;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   next_count;
  logic [SUM_W-1:0]   sum_adj;
  logic [PIX_W-1:0]   mean_calc;
  logic               accept;

  assign in_ready   = (state == LOAD);
  assign accept     = in_valid && in_ready;
  assign next_count = count + CNT_W'(1);
  // Rounded sum cannot overflow SUM_W: (2^PIX_W-1)*N + N/2 < 2^PIX_W*N.
  assign sum_adj    = (ROUND != 0) ? (sum + HALF_N) : sum;
  assign mean_calc  = PIX_W'(sum_adj >> SHIFT);

  function automatic logic [PIX_W:0] sub_mean(input logic [PIX_W-1:0] pix,
                                              input logic [PIX_W-1:0] m);
    return {1'b0, pix} - {1'b0, m};
  endfunction

  always_ff @(posedge clk) begin
    if (accept && !flush)
      pix_buf[count] <= in_pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      count     <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      mean      <= '0;
    end else if (flush) begin
      state     <= LOAD;
      count     <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            sum   <= sum + SUM_W'(in_pix);
            count <= next_count;
            if (count == LAST_IDX)
              state <= CALC;
          end
        end
        CALC: begin
          // First sample is presented together with the freshly computed mean.
          mean      <= mean_calc;
          count     <= '0;
          out_valid <= 1'b1;
          out_data  <= sub_mean(pix_buf[0], mean_calc);
          out_last  <= 1'b0;
          state     <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (count == LAST_IDX) begin
              state     <= LOAD;
              count     <= '0;
              sum       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              count    <= next_count;
              out_data <= sub_mean(pix_buf[next_count], mean);
              out_last <= (next_count == LAST_IDX);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_window_mean_sub_stream.sv
// tb/tb_window_mean_sub_stream.sv - randomized model-based bench, ROUND=0 and ROUND=1 instances side by side
module tb_window_mean_sub_stream;
  localparam int N = 256;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid;
  logic       out_ready = 1'b1;
  logic [7:0] in_pix;
  logic       ir [2];
  logic       ov [2];
  logic       ol [2];
  logic [8:0] od [2];
  logic [7:0] mn [2];

  always #5 clk = ~clk;

  window_mean_sub_stream #(.PIX_W(8), .WIN_DIM(16), .ROUND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_pix(in_pix), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_last(ol[0]), .mean(mn[0]));

  window_mean_sub_stream #(.PIX_W(8), .WIN_DIM(16), .ROUND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_pix(in_pix), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_last(ol[1]), .mean(mn[1]));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = -100;
  bit bp       = 1'b0;
  bit gaps     = 1'b0;

  logic [7:0] wpix [N];
  logic [7:0] winq [$];
  logic [7:0] xp [N];
  bit         have [2];
  int         rd [2];
  int         emean [2];
  bit         first_out [2];
  bit         prev_stall [2];
  logic [8:0] prev_data [2];
  logic       prev_last [2];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: collect accepted pixels, and once a window is complete
  // derive the mean with plain integer division and the expected sample list.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n || flush) begin
      winq.delete();
      for (int d = 0; d < 2; d++) begin
        have[d] = 0; rd[d] = 0; prev_stall[d] = 0; first_out[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk("in_ready", ir[d], !have[d]);
        if (ov[d]) begin
          if (prev_stall[d]) begin
            chk("hold_data", od[d], prev_data[d]);
            chk("hold_last", ol[d], prev_last[d]);
          end
          if (!have[d]) chk("spurious_out_valid", 1, 0);
          else begin
            chk("out_data", $signed(od[d]), int'(xp[rd[d]]) - emean[d]);
            chk("out_last", ol[d], rd[d] == N - 1);
            chk("mean", mn[d], emean[d]);
            if (first_out[d]) begin
              chk("first_out_latency", cyc - last_acc, 2);
              first_out[d] = 0;
            end
            if (out_ready) begin
              rd[d]++;
              if (rd[d] == N) have[d] = 0;
            end
          end
          prev_stall[d] = !out_ready;
          prev_data[d]  = od[d];
          prev_last[d]  = ol[d];
        end else begin
          if (prev_stall[d]) chk("valid_dropped", 0, 1);
          if (have[d] && !first_out[d]) chk("out_valid_gap", 0, 1);
          prev_stall[d] = 0;
        end
      end
      if (in_valid && ir[0]) begin
        winq.push_back(in_pix);
        if (winq.size() == N) begin
          int s;
          s = 0;
          foreach (winq[i]) begin
            xp[i] = winq[i];
            s += int'(winq[i]);
          end
          emean[0] = s / N;
          emean[1] = (s + N / 2) / N;
          for (int d = 0; d < 2; d++) begin
            have[d] = 1; rd[d] = 0; first_out[d] = 1;
          end
          last_acc = cyc;
          winq.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic push_pix(input logic [7:0] p);
    bit ok;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_pix   = p;
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (ir[0]) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_window();
    for (int i = 0; i < N; i++) push_pix(wpix[i]);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (!have[0] && !have[1] && !ov[0] && !ov[1]) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pix   = 8'd7;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < N; i++) wpix[i] = v;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) wpix[i] = 8'(i);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pix = '0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", ir[d], 1);
      chk("reset_out_valid", ov[d], 0);
      chk("reset_out_last", ol[d], 0);
      chk("reset_out_data", od[d], 0);
      chk("reset_mean", mn[d], 0);
    end
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;

    fill_const(8'd100); send_window(); wait_drain();
    chk("const_mean_r0", mn[0], 100);
    chk("const_mean_r1", mn[1], 100);

    for (int i = 0; i < 50; i++) push_pix(8'($urandom_range(0, 255)));
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_reset_in_ready", ir[d], 1);
      chk("async_reset_out_valid", ov[d], 0);
      chk("async_reset_mean", mn[d], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    fill_ramp(); send_window(); wait_drain();
    chk("ramp_mean_r0", mn[0], 127);
    chk("ramp_mean_r1", mn[1], 128);

    fill_const(8'd255); send_window(); wait_drain();
    chk("max_mean_r0", mn[0], 255);
    chk("max_mean_r1", mn[1], 255);
    fill_const(8'd0); wpix[0] = 8'd255; send_window(); wait_drain();
    chk("single_mean_r0", mn[0], 0);
    chk("single_mean_r1", mn[1], 1);
    fill_const(8'd0); send_window(); wait_drain();
    chk("zero_mean_r0", mn[0], 0);

    bp = 1'b1; gaps = 1'b1;
    for (int i = 0; i < N; i++) wpix[i] = 8'($urandom_range(0, 255));
    send_window(); wait_drain();
    fill_ramp(); send_window(); wait_drain();
    chk("bp_ramp_mean_r0", mn[0], 127);
    chk("bp_ramp_mean_r1", mn[1], 128);

    for (int i = 0; i < 100; i++) push_pix(8'($urandom_range(0, 255)));
    do_flush();
    chk("flush_in_ready", ir[0], 1);
    chk("flush_mean_kept_r0", mn[0], 127);
    chk("flush_mean_kept_r1", mn[1], 128);

    fill_ramp(); send_window();
    ok = 0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (rd[0] >= 50) begin ok = 1; break; end
    end
    if (!ok) chk("mid_drain_timeout", 0, 1);
    @(posedge clk); #1;
    do_flush();
    repeat (10) begin
      chk("post_flush_out_valid", ov[0], 0);
      @(posedge clk); #1;
    end
    bp = 1'b0; gaps = 1'b0;

    fill_const(8'd50); send_window(); wait_drain();
    chk("after_flush_mean_r0", mn[0], 50);
    chk("after_flush_mean_r1", mn[1], 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
